// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - two-stage pipelined ALU execute unit with valid/ready handshakes and flush
module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            branch_taken,
  output logic            illegal_op
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_BLT = 3'b100;
  localparam logic [2:0] OP_BGE = 3'b101;
  localparam logic [2:0] OP_BEQ = 3'b110;

  logic            s1_valid_q;
  logic [2:0]      s1_op_q;
  logic [XLEN-1:0] s1_a_q;
  logic [XLEN-1:0] s1_b_q;

  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            branch_q;
  logic            illegal_q;

  logic            s2_adv;
  logic [XLEN-1:0] diff;
  logic            a_lt_b;
  logic [XLEN-1:0] result_d;
  logic            branch_d;
  logic            illegal_d;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  assign diff   = s1_a_q - s1_b_q;
  assign a_lt_b = $signed(s1_a_q) < $signed(s1_b_q);

  always_comb begin
    result_d  = '0;
    branch_d  = 1'b0;
    illegal_d = 1'b0;
    case (s1_op_q)
      OP_AND: result_d = s1_a_q & s1_b_q;
      OP_OR:  result_d = s1_a_q | s1_b_q;
      OP_ADD: result_d = s1_a_q + s1_b_q;
      OP_SUB: result_d = diff;
      OP_BLT: begin
        result_d = diff;
        branch_d = a_lt_b;
      end
      OP_BGE: begin
        result_d = diff;
        branch_d = !a_lt_b;
      end
      OP_BEQ: begin
        result_d = diff;
        branch_d = (s1_a_q == s1_b_q);
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Bubbles load zeroed values so flags never show stale data while out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      branch_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (flush) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      branch_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        result_q    <= s1_valid_q ? result_d : '0;
        zero_q      <= s1_valid_q && (result_d == '0);
        branch_q    <= s1_valid_q && branch_d;
        illegal_q   <= s1_valid_q && illegal_d;
      end
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_op_q <= alu_ctrl;
      s1_a_q  <= op_a;
      s1_b_q  <= op_b;
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign zero         = zero_q;
  assign branch_taken = branch_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - scoreboard bench for alu_exec with directed and randomized traffic
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alu_ctrl = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        branch_taken;
  logic        illegal_op;

  alu_exec #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .branch_taken(branch_taken), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        b;
    logic        i;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model from the opcode table: plain integer arithmetic and signed comparison.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    e = '0;
    case (op)
      3'd0: e.r = a & b;
      3'd1: e.r = a | b;
      3'd2: e.r = 32'(a + b);
      3'd3: e.r = 32'(a - b);
      3'd4: begin e.r = 32'(a - b); e.b = (sa < sb); end
      3'd5: begin e.r = 32'(a - b); e.b = (sa >= sb); end
      3'd6: begin e.r = 32'(a - b); e.b = (a == b); end
      default: begin e.r = 32'd0; e.i = 1'b1; end
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  // Presents one op and holds it until accepted; returns just after the transfer edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit done = 0;
    in_valid = 1'b1;
    alu_ctrl = op;
    op_a = a;
    op_b = b;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        if (!flush && !rst) exp_q.push_back(model(op, a, b));
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("issue_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every output transfer, checks stall stability and post-kill flags.
  bit   held_v = 0;
  bit   kill_seen = 0;
  exp_t held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (held_v && out_valid) begin
        chk("hold_result", result, held.r);
        chk("hold_flags", {zero, branch_taken, illegal_op}, {held.z, held.b, held.i});
      end
      if (kill_seen && !out_valid)
        chk("idle_flags", {zero, branch_taken, illegal_op}, 3'b000);
      if (out_valid) kill_seen = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_result", result, e.r);
          chk("out_zero", zero, e.z);
          chk("out_branch", branch_taken, e.b);
          chk("out_illegal", illegal_op, e.i);
        end
      end
    end
    held_v = out_valid && !out_ready && !rst && !flush;
    held   = '{r: result, z: zero, b: branch_taken, i: illegal_op};
    if (rst || flush) kill_seen = 1;
  end

  initial begin
    int  c0;
    bit  acc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_outputs", {result, zero, branch_taken, illegal_op}, 35'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;

    // Latency: out_valid exactly two cycles after the op is presented.
    issue(3'd2, 32'd5, 32'd3);
    @(negedge clk);
    chk("lat_cycle1_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("lat_cycle2_valid", out_valid, 1'b1);
    chk("lat_add_result", result, 32'h8);
    chk("lat_add_flags", {zero, branch_taken, illegal_op}, 3'b000);
    @(posedge clk);
    #1;

    // Signed ops back to back at full throughput.
    c0 = cyc;
    issue(3'd3, 32'd3, 32'd5);
    issue(3'd4, 32'hFFFF_FFFF, 32'd1);
    issue(3'd5, 32'd1, 32'hFFFF_FFFF);
    issue(3'd6, 32'd7, 32'd7);
    chk("throughput_cycles", 64'(cyc - c0), 64'd4);
    repeat (4) @(negedge clk);
    chk("signed_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // Backpressure.
    out_ready = 1'b0;
    issue(3'd0, 32'h0000_F0F0, 32'h0000_FF00);
    issue(3'd1, 32'h0000_000F, 32'h0000_00F0);
    in_valid = 1'b1;
    alu_ctrl = 3'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_result", result, 32'h0000_F000);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_first", {out_valid, result}, {1'b1, 32'h0000_F000});
    @(negedge clk);
    chk("bp_second", {out_valid, result}, {1'b1, 32'h0000_00FF});
    repeat (3) @(negedge clk);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // Illegal opcode followed by a legal op.
    issue(3'd7, 32'd9, 32'd9);
    issue(3'd2, 32'd2, 32'd3);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;

    // Flush while stalled with both stages full.
    out_ready = 1'b0;
    issue(3'd2, 32'd10, 32'd20);
    issue(3'd3, 32'd40, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    exp_q.delete();
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_flags", {zero, branch_taken, illegal_op}, 3'b000);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;

    // Reset during a stall.
    out_ready = 1'b0;
    issue(3'd1, 32'd1, 32'd2);
    issue(3'd0, 32'd3, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_flags", {zero, branch_taken, illegal_op}, 3'b000);
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(3'd2, 32'd1, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("rst_add_result", {out_valid, result}, {1'b1, 32'd2});
    @(posedge clk);
    #1;

    // Randomized traffic with backpressure and occasional flushes.
    acc = 1;
    for (int n = 0; n < 2000; n++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom % 4) != 0;
        alu_ctrl = 3'($urandom);
        op_a = pick();
        op_b = (($urandom % 5) == 0) ? op_a : pick();
      end
      out_ready = ($urandom % 3) != 0;
      flush = !out_ready && (($urandom % 25) == 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (flush) exp_q.delete();
      else if (acc) exp_q.push_back(model(alu_ctrl, op_a, op_b));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("random_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
